sram_access_sequencer: RTL and testbench

- Sequences every data-memory access the EX stage issues (MEM_R_EN/MEM_W_EN with ALU_out as address) onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two halfword transfers.
- Deasserts `ready` for the whole transfer; the pipeline freeze logic uses it to hold IF/ID/EX/MEM.
- Sits in the MEM stage, between the EX/MEM register and the MEM/WB register.

---
 rtl/sram_access_sequencer.sv | 122 ++++++++++++
 tb/tb_sram_access_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_sequencer.sv
// MEM-stage sequencer: splits each 32-bit load/store into two
// halfword phases on an external 16-bit asynchronous SRAM.
module sram_access_sequencer #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] data_q, data_d;
  logic        op_q, op_d;
  logic [31:0] rdata_q, rdata_d;

  logic busy;
  logic hi;
  logic wr_act;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          // wrap-around subtract, then keep the low 17 word bits
          word_d  = 17'((address - 32'(ADDR_BASE)) >> 2);
          data_d  = write_data;
          op_d    = wr_en;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = HIGH;
          if (!op_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!op_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      op_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    busy   = (state_q == LOW) || (state_q == HIGH);
    hi     = (state_q == HIGH);
    wr_act = busy && op_q;

    sram_addr   = busy ? {word_q, hi} : '0;
    sram_dq_out = '0;
    if (wr_act) sram_dq_out = hi ? data_q[31:16] : data_q[15:0];
    sram_dq_oe  = wr_act;
    sram_we_n   = !wr_act;
    read_data   = rdata_q;

    // request cycle already stalls the pipeline
    if (state_q == IDLE) ready = !(rd_en | wr_en);
    else                 ready = (state_q == DONE);
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a small
// asynchronous SRAM model that needs a full-width write pulse.
`timescale 1ns/1ps
module tb_sram_access_sequencer;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;
  int pulses;

  logic [15:0] mem [0:255];
  logic [17:0] run_addr;
  int          run_len;

  sram_access_sequencer #(
    .WAIT_CYCLES(2),
    .ADDR_BASE(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(negedge clk) begin
    if (!sram_we_n) begin
      if (run_len > 0 && sram_addr == run_addr) run_len = run_len + 1;
      else run_len = 1;
      run_addr = sram_addr;
      if (run_len == 2) mem[sram_addr[7:0]] = sram_dq_out;
    end else begin
      run_len = 0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    run_len    = 0;
    run_addr   = '0;
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    write_data = '0;

    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe", sram_dq_oe, 1'b0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", sram_addr, 18'h0);
    chk("rst_dq", sram_dq_out, 16'h0);

    tick();
    wr_en      = 1'b1;
    address    = 32'd1032;
    write_data = 32'hDEADBEEF;
    #1;
    chk("wr_c0_ready", ready, 1'b0);
    tick();
    wr_en = 1'b0;
    chk("wr_c1_addr", sram_addr, 18'd4);
    chk("wr_c1_dq", sram_dq_out, 16'hBEEF);
    chk("wr_c1_we", sram_we_n, 1'b0);
    chk("wr_c1_oe", sram_dq_oe, 1'b1);
    chk("wr_c1_ready", ready, 1'b0);
    tick();
    chk("wr_c2_addr", sram_addr, 18'd4);
    chk("wr_c2_we", sram_we_n, 1'b0);
    chk("wr_c2_ready", ready, 1'b0);
    tick();
    chk("wr_c3_addr", sram_addr, 18'd5);
    chk("wr_c3_dq", sram_dq_out, 16'hDEAD);
    chk("wr_c3_we", sram_we_n, 1'b0);
    chk("wr_c3_ready", ready, 1'b0);
    tick();
    chk("wr_c4_addr", sram_addr, 18'd5);
    chk("wr_c4_dq", sram_dq_out, 16'hDEAD);
    chk("wr_c4_ready", ready, 1'b0);
    tick();
    chk("wr_c5_ready", ready, 1'b1);
    chk("wr_c5_we", sram_we_n, 1'b1);
    chk("wr_c5_oe", sram_dq_oe, 1'b0);
    chk("wr_mem4", mem[4], 16'hBEEF);
    chk("wr_mem5", mem[5], 16'hDEAD);
    chk("wr_rdata", read_data, 32'h0);

    tick();
    rd_en   = 1'b1;
    address = 32'd1032;
    #1;
    chk("rd_c0_ready", ready, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      rd_en = 1'b0;
      chk("rd_we", sram_we_n, 1'b1);
      chk("rd_oe", sram_dq_oe, 1'b0);
      chk("rd_ready", ready, 1'b0);
    end
    tick();
    chk("rd_c5_ready", ready, 1'b1);
    chk("rd_c5_we", sram_we_n, 1'b1);
    chk("rd_c5_data", read_data, 32'hDEADBEEF);

    tick();
    rd_en      = 1'b1;
    wr_en      = 1'b1;
    address    = 32'd1040;
    write_data = 32'h12345678;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("both_c1_we", sram_we_n, 1'b0);
    chk("both_c1_addr", sram_addr, 18'd8);
    tick();
    tick();
    chk("both_c3_dq", sram_dq_out, 16'h1234);
    tick();
    tick();
    chk("both_c5_ready", ready, 1'b1);
    chk("both_rdata", read_data, 32'hDEADBEEF);
    chk("both_mem8", mem[8], 16'h5678);
    chk("both_mem9", mem[9], 16'h1234);

    tick();
    pulses     = 0;
    wr_en      = 1'b1;
    address    = 32'd1056;
    write_data = 32'hCAFEF00D;
    #1;
    if (ready) pulses++;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) begin
        wr_en = 1'b0;
        rd_en = 1'b1;
      end
      if (c == 11) rd_en = 1'b0;
      #1;
      if (ready) pulses++;
      if (c == 6) chk("b2b_c6_ready", ready, 1'b0);
      if (c == 7) chk("b2b_c7_addr", sram_addr, 18'd16);
      if (c == 7) chk("b2b_c7_we", sram_we_n, 1'b1);
      if (c == 11) chk("b2b_c11_ready", ready, 1'b1);
    end
    chk("b2b_pulses", pulses, 2);
    chk("b2b_mem16", mem[16], 16'hF00D);
    chk("b2b_mem17", mem[17], 16'hCAFE);
    chk("b2b_rdata", read_data, 32'hCAFEF00D);

    tick();
    wr_en      = 1'b1;
    address    = 32'd1072;
    write_data = 32'hAAAA5555;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    chk("rstmid_c3_addr", sram_addr, 18'd25);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_we", sram_we_n, 1'b1);
    chk("rstmid_oe", sram_dq_oe, 1'b0);
    chk("rstmid_ready", ready, 1'b1);
    chk("rstmid_rdata", read_data, 32'h0);
    chk("rstmid_mem24", mem[24], 16'h5555);
    chk("rstmid_mem25", mem[25], 16'h0000);

    tick();
    wr_en      = 1'b1;
    address    = 32'd1024 + 32'd524288 + 32'd4;
    write_data = 32'h0001_0002;
    tick();
    wr_en = 1'b0;
    chk("wrap_c1_addr", sram_addr, 18'd2);
    tick();
    tick();
    chk("wrap_c3_addr", sram_addr, 18'd3);
    tick();
    tick();
    chk("wrap_c5_ready", ready, 1'b1);
    chk("wrap_mem2", mem[2], 16'h0002);
    chk("wrap_mem3", mem[3], 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
